// File: rtl/mcc_seq_adder_ctrl.sv
// mcc_seq_adder_ctrl
//   Performs one WIDTH-bit addition by time-multiplexing an external SLICE-bit
//   dynamic Manchester-carry-chain adder slice over WIDTH/SLICE chunks, LSB
//   chunk first. Each chunk gets PRE_CYCLES of precharge followed by
//   EVAL_CYCLES of evaluate. The carry out of one chunk is fed into the next.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin   operands and carry-in
//   out_valid/out_ready  result handshake
//   out_sum, out_cout    result, held stable while out_valid is high
//   busy                 high while an operation is in flight (PRE/EVAL/DONE)
//   slc_pre, slc_eval    precharge / evaluate phase strobes to the slice
//   slc_a, slc_b, slc_cin  current chunk operands and carry into the slice
//   slc_sum, slc_cout    slice results, sampled on the last evaluate cycle
module mcc_seq_adder_ctrl #(
    parameter int WIDTH       = 64,
    parameter int SLICE       = 16,
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic             slc_pre,
    output logic             slc_eval,
    output logic [SLICE-1:0] slc_a,
    output logic [SLICE-1:0] slc_b,
    output logic             slc_cin,
    input  logic [SLICE-1:0] slc_sum,
    input  logic             slc_cout
);

    localparam int N    = WIDTH / SLICE;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int PMAX = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRE_CYCLES - 1);
    localparam logic [PW-1:0] EVAL_LAST  = PW'(EVAL_CYCLES - 1);

    generate
        if ((WIDTH % SLICE != 0) || (SLICE < 4) || (PRE_CYCLES < 1) || (EVAL_CYCLES < 1)) begin : g_bad_params
            $error("mcc_seq_adder_ctrl: illegal WIDTH/SLICE/PRE_CYCLES/EVAL_CYCLES combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    chunk_q, chunk_d;
    logic [PW-1:0]    phase_q, phase_d;
    // Operands are kept pre-shifted so the next chunk is always in the low bits.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Result accumulates from the top down; after N chunks chunk 0 sits at the LSB.
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             slc_pre_q, slc_pre_d;
    logic             slc_eval_q, slc_eval_d;
    logic [SLICE-1:0] slc_a_q, slc_a_d;
    logic [SLICE-1:0] slc_b_q, slc_b_d;
    // slc_cin_q doubles as the inter-chunk carry register.
    logic             slc_cin_q, slc_cin_d;

    // Next-state and next-output computation for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        chunk_d     = chunk_q;
        phase_d     = phase_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        slc_pre_d   = slc_pre_q;
        slc_eval_d  = slc_eval_q;
        slc_a_d     = slc_a_q;
        slc_b_d     = slc_b_q;
        slc_cin_d   = slc_cin_q;

        res_shift                      = res_q >> SLICE;
        res_shift[WIDTH-1 -: SLICE]    = slc_sum;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_PRE;
                    chunk_d    = '0;
                    phase_d    = '0;
                    a_d        = in_a >> SLICE;
                    b_d        = in_b >> SLICE;
                    res_d      = '0;
                    slc_a_d    = in_a[SLICE-1:0];
                    slc_b_d    = in_b[SLICE-1:0];
                    slc_cin_d  = in_cin;
                    slc_pre_d  = 1'b1;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (phase_q == PRE_LAST) begin
                    state_d    = ST_EVAL;
                    phase_d    = '0;
                    slc_pre_d  = 1'b0;
                    slc_eval_d = 1'b1;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_EVAL: begin
                if (phase_q == EVAL_LAST) begin
                    phase_d    = '0;
                    slc_eval_d = 1'b0;
                    res_d      = res_shift;
                    if (chunk_q == LAST_CHUNK) begin
                        state_d     = ST_DONE;
                        out_sum_d   = res_shift;
                        out_cout_d  = slc_cout;
                        out_valid_d = 1'b1;
                    end else begin
                        // Next chunk's operands and carry change only here, on PRE entry.
                        state_d   = ST_PRE;
                        chunk_d   = chunk_q + CW'(1);
                        a_d       = a_q >> SLICE;
                        b_d       = b_q >> SLICE;
                        slc_a_d   = a_q[SLICE-1:0];
                        slc_b_d   = b_q[SLICE-1:0];
                        slc_cin_d = slc_cout;
                        slc_pre_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_DONE: begin
                // Returning to IDLE never accepts an operand in the same cycle.
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                slc_pre_d   = 1'b0;
                slc_eval_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            chunk_q     <= '0;
            phase_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            slc_pre_q   <= 1'b0;
            slc_eval_q  <= 1'b0;
            slc_a_q     <= '0;
            slc_b_q     <= '0;
            slc_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            chunk_q     <= chunk_d;
            phase_q     <= phase_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            slc_pre_q   <= slc_pre_d;
            slc_eval_q  <= slc_eval_d;
            slc_a_q     <= slc_a_d;
            slc_b_q     <= slc_b_d;
            slc_cin_q   <= slc_cin_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign busy      = busy_q;
    assign slc_pre   = slc_pre_q;
    assign slc_eval  = slc_eval_q;
    assign slc_a     = slc_a_q;
    assign slc_b     = slc_b_q;
    assign slc_cin   = slc_cin_q;

endmodule

// File: tb/tb_mcc_seq_adder_ctrl.sv
// Testbench for mcc_seq_adder_ctrl: default instance (64/16, 1/1) plus a
// second instance with PRE_CYCLES=2, EVAL_CYCLES=3 for phase timing.
// Each instance is attached to a behavioural dynamic slice that only
// produces a valid sum while slc_eval is high.
module tb_mcc_seq_adder_ctrl;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [63:0] in_a, in_b, out_sum;
    logic        slc_pre, slc_eval, slc_cin, slc_cout;
    logic [15:0] slc_a, slc_b, slc_sum;

    logic        p_in_valid, p_in_ready, p_in_cin, p_out_valid, p_out_ready, p_out_cout, p_busy;
    logic [63:0] p_in_a, p_in_b, p_out_sum;
    logic        p_slc_pre, p_slc_eval, p_slc_cin, p_slc_cout;
    logic [15:0] p_slc_a, p_slc_b, p_slc_sum;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    mcc_seq_adder_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
        .slc_pre(slc_pre), .slc_eval(slc_eval),
        .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin),
        .slc_sum(slc_sum), .slc_cout(slc_cout)
    );

    mcc_seq_adder_ctrl #(.WIDTH(64), .SLICE(16), .PRE_CYCLES(2), .EVAL_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_a(p_in_a), .in_b(p_in_b), .in_cin(p_in_cin),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_sum(p_out_sum), .out_cout(p_out_cout), .busy(p_busy),
        .slc_pre(p_slc_pre), .slc_eval(p_slc_eval),
        .slc_a(p_slc_a), .slc_b(p_slc_b), .slc_cin(p_slc_cin),
        .slc_sum(p_slc_sum), .slc_cout(p_slc_cout)
    );

    // Behavioural slices: output is only meaningful during evaluate.
    assign {slc_cout, slc_sum} = slc_eval ?
        ({1'b0, slc_a} + {1'b0, slc_b} + {16'd0, slc_cin}) : 17'd0;
    assign {p_slc_cout, p_slc_sum} = p_slc_eval ?
        ({1'b0, p_slc_a} + {1'b0, p_slc_b} + {16'd0, p_slc_cin}) : 17'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", cmp_cnt);
        $fatal(1, "watchdog");
    end

    // Present one operand on the default instance and wait for out_valid
    // (out_ready held low). Records slc_cin at the start of each chunk.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          output logic [63:0] sum, output logic cout,
                          output int lat, output logic [3:0] cseq);
        int   ch;
        logic prev_pre;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; ch = 0; cseq = 4'b0000; prev_pre = 1'b0;
        while (!out_valid && lat < 200) begin
            if (slc_pre && !prev_pre && ch < 4) begin
                cseq[ch] = slc_cin;
                ch++;
            end
            prev_pre = slc_pre;
            @(posedge clk); #1;
            lat++;
        end
        sum = out_sum;
        cout = out_cout;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp_cnt++; if ({out_valid, busy, slc_pre, slc_eval, out_cout} !== 5'b0) begin
            fail_cnt++; $display("FAIL reset_flags: got %b required 00000", {out_valid, busy, slc_pre, slc_eval, out_cout});
        end
        cmp_cnt++; if ({out_sum, slc_a, slc_b, slc_cin} !== 97'd0) begin
            fail_cnt++; $display("FAIL reset_data: got sum=%h a=%h b=%h cin=%b required all 0", out_sum, slc_a, slc_b, slc_cin);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        cmp_cnt++; if ({in_ready, p_in_ready} !== 2'b11) begin
            fail_cnt++; $display("FAIL reset_in_ready: got %b required 11", {in_ready, p_in_ready});
        end
    endtask

    task automatic test_carry_ripple();
        logic [63:0] s; logic c; int lat; logic [3:0] cs;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, s, c, lat, cs);
        cmp_cnt++; if ({c, s} !== {1'b1, 64'd0}) begin
            fail_cnt++; $display("FAIL ripple_sum: got cout=%b sum=%h required cout=1 sum=0", c, s);
        end
        cmp_cnt++; if (cs !== 4'b1110) begin
            fail_cnt++; $display("FAIL ripple_cin_seq: got %b required 1110 (chunk3..0)", cs);
        end
        cmp_cnt++; if (lat !== 8) begin
            fail_cnt++; $display("FAIL ripple_latency: got %0d required 8", lat);
        end
        cmp_cnt++; if ({in_ready, busy, slc_pre, slc_eval} !== 4'b0100) begin
            fail_cnt++; $display("FAIL done_flags: got %b required 0100", {in_ready, busy, slc_pre, slc_eval});
        end
        finish_op();
        cmp_cnt++; if ({out_valid, in_ready, busy} !== 3'b010) begin
            fail_cnt++; $display("FAIL after_handshake: got %b required 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_complement();
        logic [63:0] s; logic c; int lat; logic [3:0] cs;
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, s, c, lat, cs);
        cmp_cnt++; if ({c, s} !== {1'b1, 64'd0}) begin
            fail_cnt++; $display("FAIL compl_cin1: got cout=%b sum=%h required cout=1 sum=0", c, s);
        end
        cmp_cnt++; if (cs !== 4'b1111) begin
            fail_cnt++; $display("FAIL compl_cin1_seq: got %b required 1111", cs);
        end
        finish_op();
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, s, c, lat, cs);
        cmp_cnt++; if ({c, s} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            fail_cnt++; $display("FAIL compl_cin0: got cout=%b sum=%h required cout=0 sum=ffffffffffffffff", c, s);
        end
        cmp_cnt++; if (cs !== 4'b0000) begin
            fail_cnt++; $display("FAIL compl_cin0_seq: got %b required 0000", cs);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        logic [63:0] s; logic c; int lat; logic [3:0] cs; int bad;
        run_op(64'd100, 64'd23, 1'b0, s, c, lat, cs);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_a = 64'hDEAD_BEEF_0000_0000 + 64'(i);
            in_b = 64'd999;
            @(posedge clk); #1;
            if (!(out_valid === 1'b1 && out_sum === 64'd123 && out_cout === 1'b0 && in_ready === 1'b0)) bad++;
        end
        cmp_cnt++; if (bad !== 0) begin
            fail_cnt++; $display("FAIL backpressure_hold: got %0d unstable cycles required 0 (sum=%h)", bad, out_sum);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 64'd7; in_b = 64'd8; in_cin = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        cmp_cnt++; if ({out_valid, in_ready, busy} !== 3'b010) begin
            fail_cnt++; $display("FAIL done_to_idle_no_accept: got %b required 010", {out_valid, in_ready, busy});
        end
        run_op(64'd7, 64'd8, 1'b1, s, c, lat, cs);
        cmp_cnt++; if ({c, s} !== {1'b0, 64'd16} || lat !== 8) begin
            fail_cnt++; $display("FAIL backpressure_next: got cout=%b sum=%h lat=%0d required cout=0 sum=10 lat=8", c, s, lat);
        end
        finish_op();
    endtask

    task automatic test_reset_abort();
        logic [63:0] s; logic c; int lat; logic [3:0] cs; int seen;
        in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'd1; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        cmp_cnt++; if ({slc_eval, slc_a, slc_cin} !== {1'b1, 16'hFFFF, 1'b1}) begin
            fail_cnt++; $display("FAIL abort_in_chunk2_eval: got eval=%b a=%h cin=%b required 1 ffff 1", slc_eval, slc_a, slc_cin);
        end
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++; if ({out_valid, busy, slc_pre, slc_eval, slc_cin, out_cout, slc_a, slc_b, out_sum} !== 102'd0) begin
            fail_cnt++; $display("FAIL abort_async_clear: got v=%b busy=%b pre=%b eval=%b a=%h sum=%h required all 0",
                                 out_valid, busy, slc_pre, slc_eval, slc_a, out_sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        cmp_cnt++; if (in_ready !== 1'b1 || seen !== 0) begin
            fail_cnt++; $display("FAIL abort_after_release: got in_ready=%b out_valid_cycles=%0d required 1 and 0", in_ready, seen);
        end
        run_op(64'd5, 64'd7, 1'b0, s, c, lat, cs);
        cmp_cnt++; if ({c, s} !== {1'b0, 64'd12}) begin
            fail_cnt++; $display("FAIL abort_next_add: got cout=%b sum=%h required cout=0 sum=c", c, s);
        end
        finish_op();
    endtask

    task automatic test_phase_timing();
        logic [63:0] a, b;
        logic [15:0] wa, wb; logic wc;
        int idx, bad_phase, bad_hold, bad_chunk;
        a = 64'h8000_FFFF_0001_FFFF;
        b = 64'h8000_0001_FFFF_0001;
        p_in_a = a; p_in_b = b; p_in_cin = 1'b0; p_in_valid = 1'b1; p_out_ready = 1'b0;
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        idx = 0; bad_phase = 0; bad_hold = 0; bad_chunk = 0;
        wa = '0; wb = '0; wc = 1'b0;
        while (!p_out_valid && idx < 100) begin
            if ((idx % 5 < 2) !== p_slc_pre || (idx % 5 >= 2) !== p_slc_eval) bad_phase++;
            if (idx % 5 == 0) begin
                wa = p_slc_a; wb = p_slc_b; wc = p_slc_cin;
                if (p_slc_a !== a[(idx / 5) * 16 +: 16] || p_slc_b !== b[(idx / 5) * 16 +: 16]) bad_chunk++;
            end else if (p_slc_a !== wa || p_slc_b !== wb || p_slc_cin !== wc) begin
                bad_hold++;
            end
            @(posedge clk); #1;
            idx++;
        end
        cmp_cnt++; if (bad_phase !== 0) begin
            fail_cnt++; $display("FAIL phase_pattern: got %0d bad cycles required 0", bad_phase);
        end
        cmp_cnt++; if (bad_hold !== 0 || bad_chunk !== 0) begin
            fail_cnt++; $display("FAIL phase_window_hold: got hold=%0d chunk=%0d bad required 0", bad_hold, bad_chunk);
        end
        cmp_cnt++; if (idx !== 20 || {p_slc_pre, p_slc_eval} !== 2'b00) begin
            fail_cnt++; $display("FAIL phase_latency: got %0d pre/eval=%b required 20 and 00", idx, {p_slc_pre, p_slc_eval});
        end
        cmp_cnt++; if ({p_out_cout, p_out_sum} !== {1'b1, 64'h0001_0001_0001_0000}) begin
            fail_cnt++; $display("FAIL phase_sum: got cout=%b sum=%h required cout=1 sum=0001000100010000", p_out_cout, p_out_sum);
        end
        p_out_ready = 1'b1;
        @(posedge clk); #1;
        p_out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b; logic cin; logic [64:0] expv;
        int hs, cyc, bad_sum, bad_ready, bad_dup, timeouts;
        bit done;
        hs = 0; bad_sum = 0; bad_ready = 0; bad_dup = 0; timeouts = 0;
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) b = ~a;
            expv = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (in_ready !== 1'b1) bad_ready++;
            in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
            @(posedge clk); #1;
            done = 1'b0; cyc = 0;
            while (!done && cyc < 100) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = {$urandom, $urandom};
                in_b = {$urandom, $urandom};
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    if ({out_cout, out_sum} !== expv) begin
                        bad_sum++;
                        if (bad_sum < 5) $display("op %0d: got %h expected %h", i, {out_cout, out_sum}, expv);
                    end
                    hs++;
                    in_valid = 1'b0;
                    done = 1'b1;
                end
                @(posedge clk); #1;
                cyc++;
            end
            out_ready = 1'b0;
            if (!done) timeouts++;
            if (out_valid !== 1'b0) bad_dup++;
        end
        cmp_cnt++; if (bad_sum !== 0) begin
            fail_cnt++; $display("FAIL random_sum: got %0d wrong results required 0", bad_sum);
        end
        cmp_cnt++; if (hs !== 1000 || timeouts !== 0) begin
            fail_cnt++; $display("FAIL random_count: got %0d results (%0d timeouts) required 1000", hs, timeouts);
        end
        cmp_cnt++; if (bad_dup !== 0 || bad_ready !== 0) begin
            fail_cnt++; $display("FAIL random_handshake: got dup=%0d not_ready=%0d required 0", bad_dup, bad_ready);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        p_in_valid = 1'b0; p_in_a = '0; p_in_b = '0; p_in_cin = 1'b0; p_out_ready = 1'b0;
        test_reset();
        test_carry_ripple();
        test_complement();
        test_backpressure();
        test_reset_abort();
        test_phase_timing();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
